// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and ALU control encodings used by the
// arbiter, the ALU itself and anything that builds requests for them.
package alu_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/ALU.sv
// Combinational 64-bit ALU: AND/OR/ADD/SUB/unsigned SLT with carry-out and zero flags.
// Unknown control codes produce a zero result with carry cleared.
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             zero
);

    logic [WIDTH:0] sumWide;
    logic [WIDTH:0] diffWide;

    assign sumWide  = {1'b0, a} + {1'b0, b};
    assign diffWide = {1'b0, a} - {1'b0, b};

    // Carry for ADD/SUB is the extra top bit of the widened sum/difference.
    always_comb begin
        result   = '0;
        carryOut = 1'b0;
        case (ALUControl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result   = sumWide[WIDTH-1:0];
                carryOut = sumWide[WIDTH];
            end
            ALU_SUB: begin
                result   = diffWide[WIDTH-1:0];
                carryOut = diffWide[WIDTH];
            end
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_rsp_slot.sv
// Single-entry response register holding one ALU result, its flags and the tag.
// A load in the same cycle as a drain keeps the slot full with the new contents.
module alu_rsp_slot #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              carry_i,
    input  logic              zero_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              zero_q;
    logic [TAG_W-1:0]  tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            tag_q    <= '0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            result_q <= result_i;
            carry_q  <= carry_i;
            zero_q   <= zero_i;
            tag_q    <= tag_i;
        end else if (valid_q && ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the execute datapath (port 0) and the
// branch/compare unit (port 1); each port gets its own registered response slot.
module alu_share_arbiter #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_carry,
    output logic              rsp0_zero,
    output logic [TAG_W-1:0]  rsp0_tag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_carry,
    output logic              rsp1_zero,
    output logic [TAG_W-1:0]  rsp1_tag
);
    import alu_pkg::*;

    logic              elig0, elig1;
    logic              grant0, grant1;
    logic              rr_q, rr_d;
    logic [DATA_W-1:0] aluA, aluB, aluResult;
    logic [3:0]        aluCtl;
    logic              aluCarry, aluZero;

    // A port may issue when its slot is empty or is being drained this cycle.
    assign elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
    assign grant0 = !reset && elig0 && (!elig1 || (rr_q == 1'b0));
    assign grant1 = !reset && elig1 && (!elig0 || (rr_q == 1'b1));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The pointer favours whichever port lost the most recent grant.
    always_comb begin
        rr_d = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        aluA   = '0;
        aluB   = '0;
        aluCtl = ALU_AND;
        if (grant0) begin
            aluA   = req0_a;
            aluB   = req0_b;
            aluCtl = req0_op;
        end else if (grant1) begin
            aluA   = req1_a;
            aluB   = req1_b;
            aluCtl = req1_op;
        end
    end

    ALU #(.WIDTH(DATA_W)) uAlu (
        .a          (aluA),
        .b          (aluB),
        .ALUControl (aluCtl),
        .result     (aluResult),
        .carryOut   (aluCarry),
        .zero       (aluZero)
    );

    alu_rsp_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) uSlot0 (
        .clk      (clk),
        .reset    (reset),
        .load_i   (grant0),
        .result_i (aluResult),
        .carry_i  (aluCarry),
        .zero_i   (aluZero),
        .tag_i    (req0_tag),
        .ready_i  (rsp0_ready),
        .valid_o  (rsp0_valid),
        .result_o (rsp0_result),
        .carry_o  (rsp0_carry),
        .zero_o   (rsp0_zero),
        .tag_o    (rsp0_tag)
    );

    alu_rsp_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) uSlot1 (
        .clk      (clk),
        .reset    (reset),
        .load_i   (grant1),
        .result_i (aluResult),
        .carry_i  (aluCarry),
        .zero_i   (aluZero),
        .tag_i    (req1_tag),
        .ready_i  (rsp1_ready),
        .valid_o  (rsp1_valid),
        .result_o (rsp1_result),
        .carry_o  (rsp1_carry),
        .zero_o   (rsp1_zero),
        .tag_o    (rsp1_tag)
    );

endmodule
